vedacao_ctrl: RTL and testbench



---
 rtl/vedacao_ctrl.sv | 158 +++++++++++++++
 tb/tb_vedacao_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vedacao_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vedacao_ctrl
// Purpose  : Sealing stage controller. When the main line FSM holds a bottle
//            in the sealing position, the capping actuator is driven for
//            T_VEDA cycles and completion is reported back. A cork stock
//            counter is kept, with operator refills from a push-button.
//            An empty stock raises an alarm so the main FSM holds the line.
// Ports    :
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   pos_ve       in   bottle held in sealing position (level)
//   add_rolha    in   refill push-button (one refill per rising edge)
//   vedar        out  capping actuator enable
//   ve_done      out  sealing complete, to main FSM
//   alarme       out  cork stock empty, to main FSM
//   rolha_baixa  out  cork stock at or below ROLHA_LOW (panel lamp)
//   rolhas       out  current cork stock count [W-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module vedacao_ctrl #(
  parameter int W           = 6,
  parameter int ROLHAS_MAX  = 20,
  parameter int ROLHAS_INIT = 20,
  parameter int REFILL_ADD  = 15,
  parameter int ROLHA_LOW   = 5,
  parameter int T_VEDA      = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pos_ve,
  input  logic         add_rolha,
  output logic         vedar,
  output logic         ve_done,
  output logic         alarme,
  output logic         rolha_baixa,
  output logic [W-1:0] rolhas
);

  // Timer counts down from T_VEDA-1 to 0, so it only needs to hold T_VEDA-1.
  localparam int TW = (T_VEDA > 1) ? $clog2(T_VEDA) : 1;

  localparam logic [TW-1:0] c_TLOAD  = TW'(T_VEDA - 1);
  localparam logic [W:0]    c_ADD    = (W+1)'(REFILL_ADD);
  localparam logic [W:0]    c_MAX    = (W+1)'(ROLHAS_MAX);
  localparam logic [W-1:0]  c_INIT   = W'(ROLHAS_INIT);
  localparam logic [W-1:0]  c_LOW    = W'(ROLHA_LOW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VEDA = 2'd1,
    ST_DONE = 2'd2,
    ST_SEM  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [W-1:0]  r_rolhas;
  logic [W-1:0]  w_rolhas_next;
  logic          r_add_q;
  logic          w_refill;
  logic          w_dec;
  logic [W:0]    w_sum;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_rolhas <= c_INIT;
      r_add_q  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_rolhas <= w_rolhas_next;
      r_add_q  <= add_rolha;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_dec        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (pos_ve) begin
          if (r_rolhas != '0) begin
            w_state_next = ST_VEDA;
            w_timer_next = c_TLOAD;
          end else begin
            w_state_next = ST_SEM;
          end
        end
      end
      ST_VEDA: begin
        // An abort from the main FSM wins over completion: no cork consumed.
        if (!pos_ve) begin
          w_state_next = ST_IDLE;
        end else if (r_timer == '0) begin
          w_state_next = ST_DONE;
          w_dec        = 1'b1;
        end else begin
          w_timer_next = r_timer - 1'b1;
        end
      end
      ST_DONE: begin
        if (!pos_ve) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SEM: begin
        if (!pos_ve) begin
          w_state_next = ST_IDLE;
        end else if (r_rolhas != '0) begin
          w_state_next = ST_VEDA;
          w_timer_next = c_TLOAD;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Stock counter: refill and decrement may coincide; the sum is formed one
  // bit wider so the refill cannot wrap before saturation.
  // --------------------------------------------------------------------------
  assign w_refill = add_rolha & ~r_add_q;

  always_comb begin
    w_sum = {1'b0, r_rolhas} - {{W{1'b0}}, w_dec} + (w_refill ? c_ADD : '0);
    if (w_sum > c_MAX) begin
      w_rolhas_next = c_MAX[W-1:0];
    end else begin
      w_rolhas_next = w_sum[W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign vedar       = (r_state == ST_VEDA);
  assign ve_done     = (r_state == ST_DONE);
  assign alarme      = (r_rolhas == '0);
  assign rolha_baixa = (r_rolhas <= c_LOW);
  assign rolhas      = r_rolhas;

endmodule
`default_nettype wire

// File: tb/tb_vedacao_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vedacao_ctrl
// Purpose  : Self-checking bench for vedacao_ctrl. A cycle-level model of the
//            sealing stage (seal progress as elapsed cycles, stock as an
//            integer with min() saturation) is compared against every output
//            on each falling edge; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vedacao_ctrl;

  localparam int W = 6;
  localparam int T_VEDA = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         pos_ve;
  logic         add_rolha;
  logic         vedar;
  logic         ve_done;
  logic         alarme;
  logic         rolha_baixa;
  logic [W-1:0] rolhas;

  int checks = 0;
  int errors = 0;

  vedacao_ctrl #(
    .W(W), .ROLHAS_MAX(20), .ROLHAS_INIT(20), .REFILL_ADD(15),
    .ROLHA_LOW(5), .T_VEDA(T_VEDA)
  ) dut (
    .clk(clk), .reset(reset), .pos_ve(pos_ve), .add_rolha(add_rolha),
    .vedar(vedar), .ve_done(ve_done), .alarme(alarme),
    .rolha_baixa(rolha_baixa), .rolhas(rolhas)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: mode 0=waiting, 1=sealing, 2=sealed, 3=no cork
  // --------------------------------------------------------------------------
  int m_stock;
  int m_mode;
  int m_elapsed;
  bit m_btn_prev;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int dec;
    int add;
    dec = 0;
    add = (add_rolha && !m_btn_prev) ? 15 : 0;
    if (reset) begin
      m_stock = 20; m_mode = 0; m_elapsed = 0; m_btn_prev = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_mode)
        0: if (pos_ve) begin
             if (m_stock > 0) begin m_mode = 1; m_elapsed = 0; end
             else m_mode = 3;
           end
        1: if (!pos_ve) m_mode = 0;
           else if (m_elapsed == T_VEDA - 1) begin m_mode = 2; dec = 1; end
           else m_elapsed++;
        2: if (!pos_ve) m_mode = 0;
        default: if (!pos_ve) m_mode = 0;
                 else if (m_stock > 0) begin m_mode = 1; m_elapsed = 0; end
      endcase
      m_stock = m_stock - dec + add;
      if (m_stock > 20) m_stock = 20;
      m_btn_prev = add_rolha;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_vedar",   int'(vedar),       int'(m_mode == 1));
      chk("m_ve_done", int'(ve_done),     int'(m_mode == 2));
      chk("m_alarme",  int'(alarme),      int'(m_stock == 0));
      chk("m_baixa",   int'(rolha_baixa), int'(m_stock <= 5));
      chk("m_rolhas",  int'(rolhas),      m_stock);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raises pos_ve, waits for ve_done (bounded), returns actuator-on cycles,
  // then releases pos_ve.
  task automatic seal(output int on_cycles);
    bit got;
    on_cycles = 0;
    got = 1'b0;
    pos_ve = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ve_done) got = 1'b1;
      else if (vedar) on_cycles++;
    end
    chk("seal_done_timeout", int'(got), 1);
    @(posedge clk); #1;
    pos_ve = 1'b0;
    cyc(1);
  endtask

  initial begin
    int n;
    reset = 1'b1; pos_ve = 1'b0; add_rolha = 1'b0;
    cyc(2);
    chk("reset_rolhas", int'(rolhas), 20);
    chk("reset_vedar", int'(vedar), 0);
    chk("reset_alarme", int'(alarme), 0);
    reset = 1'b0;
    cyc(1);

    // First seal: 4 actuator cycles, stock 20 -> 19
    seal(n);
    chk("vedar_cycles", n, 4);
    chk("rolhas_after_1", int'(rolhas), 19);
    chk("ve_done_dropped", int'(ve_done), 0);

    // Down to 6 (no lamp), then 5 (lamp)
    for (int k = 0; k < 13; k++) seal(n);
    chk("rolhas_6", int'(rolhas), 6);
    chk("baixa_at_6", int'(rolha_baixa), 0);
    seal(n);
    chk("rolhas_5", int'(rolhas), 5);
    chk("baixa_at_5", int'(rolha_baixa), 1);
    for (int k = 0; k < 5; k++) seal(n);
    chk("rolhas_0", int'(rolhas), 0);
    chk("alarme_empty", int'(alarme), 1);

    // Empty stock: no actuation
    pos_ve = 1'b1;
    cyc(2);
    chk("sem_vedar", int'(vedar), 0);
    chk("sem_alarme", int'(alarme), 1);
    add_rolha = 1'b1;
    cyc(1);
    chk("sem_refill", int'(rolhas), 15);
    chk("sem_alarme_clr", int'(alarme), 0);
    add_rolha = 1'b0;
    cyc(1);
    chk("sem_to_veda", int'(vedar), 1);
    seal(n);
    chk("rolhas_14", int'(rolhas), 14);

    // Held button gives one saturating refill
    for (int k = 0; k < 4; k++) seal(n);
    chk("rolhas_10", int'(rolhas), 10);
    add_rolha = 1'b1;
    cyc(5);
    chk("refill_sat", int'(rolhas), 20);
    add_rolha = 1'b0;
    cyc(1);
    add_rolha = 1'b1;
    cyc(1);
    add_rolha = 1'b0;
    chk("refill_sat2", int'(rolhas), 20);

    // Refill coinciding with the decrement at stock 3
    for (int k = 0; k < 17; k++) seal(n);
    chk("rolhas_3", int'(rolhas), 3);
    pos_ve = 1'b1;
    cyc(4);
    add_rolha = 1'b1;
    cyc(1);
    chk("simul_done", int'(ve_done), 1);
    chk("simul_rolhas", int'(rolhas), 17);
    add_rolha = 1'b0; pos_ve = 1'b0;
    cyc(1);

    // Abort in 2nd sealing cycle
    pos_ve = 1'b1;
    cyc(2);
    chk("abort_vedar_on", int'(vedar), 1);
    pos_ve = 1'b0;
    cyc(1);
    chk("abort_vedar_off", int'(vedar), 0);
    cyc(3);
    chk("abort_no_done", int'(ve_done), 0);
    chk("abort_rolhas", int'(rolhas), 17);

    // Reset mid-seal
    pos_ve = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk("rst_mid_vedar", int'(vedar), 0);
    chk("rst_mid_done", int'(ve_done), 0);
    chk("rst_mid_rolhas", int'(rolhas), 20);
    reset = 1'b0; pos_ve = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
